// File: rtl/data_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_responder
// Description : Memory-side responder for the CPU data SRAM-like port.
//               Accepts byte/half/word loads and stores, applies byte-enabled
//               writes to a local word array and returns read data in order
//               after a fixed LATENCY through a shift pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module data_sram_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2,
    parameter int MAX_OUT    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic [31:0] rdata,
    output logic        data_ok,
    output logic        err
);
    localparam int                 c_CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(MAX_OUT);
    localparam int                 c_DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0]           r_mem [c_DEPTH];
    logic                  r_resetn_q;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_pv [LATENCY];
    logic [31:0]           r_pd [LATENCY];
    logic                  r_err;

    logic                  w_accept;
    logic                  w_misaligned;
    logic                  w_store;
    logic [3:0]            w_strb;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [31:0]           w_ld;
    logic                  w_unused;

    // Address bits above the word index alias; they are deliberately ignored.
    assign w_unused = ^addr[31:ADDR_WIDTH+2];
    assign w_idx    = addr[ADDR_WIDTH+1:2];

    // Acceptance is offered purely from registered state so there is no
    // combinational path from req to addr_ok.
    assign addr_ok  = r_resetn_q & (r_count < c_MAX);
    assign w_accept = req & addr_ok & resetn;
    assign w_store  = w_accept & wr & ~w_misaligned;

    // Lane strobes and alignment check from access size and low address bits.
    always_comb begin
        w_strb       = 4'b0000;
        w_misaligned = 1'b0;
        case (size)
            2'd0: w_strb = 4'b0001 << addr[1:0];
            2'd1: begin
                w_strb       = 4'b0011 << addr[1:0];
                w_misaligned = addr[0];
            end
            2'd2: begin
                w_strb       = 4'b1111;
                w_misaligned = (addr[1:0] != 2'b00);
            end
            default: w_misaligned = 1'b1;
        endcase
    end

    // Stores and faulty requests answer with zero; good loads return the word.
    assign w_ld = (wr | w_misaligned) ? 32'h0 : r_mem[w_idx];

    // Byte-enabled write into the word array; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_store) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered copy of resetn holds addr_ok low for one cycle after release.
    always_ff @(posedge clk) begin
        r_resetn_q <= resetn;
    end

    // Fixed-latency response pipeline; the last stage drives data_ok/rdata.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_pd[i] <= 32'h0;
            end
        end else begin
            r_pv[0] <= w_accept;
            r_pd[0] <= w_accept ? w_ld : 32'h0;
            for (int i = 1; i < LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    assign data_ok = r_pv[LATENCY-1];
    assign rdata   = r_pd[LATENCY-1];

    // Outstanding count: a retiring slot only becomes usable the next cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count <= '0;
        end else begin
            case ({w_accept, data_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flag for misaligned or illegal-size requests.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_err <= 1'b0;
        end else if (w_accept & w_misaligned) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

endmodule
`default_nettype wire
